// File: rtl/mmio_uart_tx_if.sv
// MMIO bus between the CPU memory stage and the UART transmitter.
// Strobes arrive already qualified by the CPU. Read data is registered in the slave.
interface mmio_uart_tx_if;
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output re,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  re,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter.
// Stores to ADDR_DATA queue bytes in a TX FIFO. A bit-serial FSM drains the FIFO
// onto an 8N1 line. Loads of ADDR_STATUS return a status word one cycle later.
// Optional feature macro MMIO_UART_TX_PARITY_EN adds an even-parity bit after
// the data bits, giving 8E1 framing, and sets status bit4.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] ADDR_DATA    = 16'h0020,
    parameter logic [15:0] ADDR_STATUS  = 16'h0024
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          uart_tx,
    output logic          tx_busy,
    output logic          fifo_full
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic       PARITY_FLAG = 1'b1;
`else
    localparam logic       PARITY_FLAG = 1'b0;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;

    logic [2:0]    state;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    frame_data;
    logic          tx_reg;
    logic [31:0]   rdata_reg;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          status_rd;
    logic          baud_done;
    logic [31:0]   status_word;

    // Only the low byte of a store reaches the data register.
    logic          unused_wdata;
    assign unused_wdata = ^bus.wdata[31:8];

    assign push_req  = bus.we && (bus.addr == ADDR_DATA);
    assign pop       = (state == S_IDLE) && (count != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push      = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;
    assign status_rd = bus.re && (bus.addr == ADDR_STATUS);
    assign baud_done = (baud_cnt == BAUD_LAST);

    assign tx_busy   = (state != S_IDLE) || (count != '0);
    assign fifo_full = (count == FULL_COUNT);
    assign uart_tx   = tx_reg;
    assign bus.rdata = rdata_reg;

    // With FIFO_DEPTH = 256 a full count wraps to 0 in the 8-bit field; bit1 disambiguates.
    assign status_word = {16'h0000, 8'(count), 3'b000, PARITY_FLAG,
                          overflow, tx_busy, fifo_full, (count == '0)};

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values,
        // so the pointer, count and FSM updates below cannot race each other.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entries are only read
        // when count says they are valid, and leaving it out keeps it a plain RAM.
        if (push) mem[wr_ptr] <= bus.wdata[7:0];
    end

    // Registered status read and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg <= '0;
            overflow  <= 1'b0;
        end else begin
            if (bus.re) rdata_reg <= status_rd ? status_word : 32'h0;
            // A drop in the same cycle as a status read stays visible for the next read.
            if (drop)           overflow <= 1'b1;
            else if (status_rd) overflow <= 1'b0;
        end
    end

    // Serial framing FSM: start bit, 8 data bits LSB first, optional parity, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            frame_data <= '0;
            tx_reg     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        frame_data <= mem[rd_ptr];
                        baud_cnt   <= '0;
                        tx_reg     <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_reg   <= frame_data[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            tx_reg <= ^frame_data;
                            state  <= S_PARITY;
`else
                            tx_reg <= 1'b1;
                            state  <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_reg  <= frame_data[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx_reg   <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    tx_reg   <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT = 4 and FIFO_DEPTH = 16.
// A line monitor decodes frames from uart_tx; expected bytes, frame timing and
// status words come from a model built on the framing rules.
module tb_mmio_uart_tx;

    localparam int          CPB         = 4;
    localparam int          DEPTH       = 16;
    localparam logic [15:0] ADDR_DATA   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0024;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
    localparam logic [31:0] PAR_FLAG = 32'h0000_0010;
`else
    localparam int          NBITS    = 10;
    localparam logic [31:0] PAR_FLAG = 32'h0000_0000;
`endif
    localparam int          FRAME = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        bit         ok;
    } rx_t;

    logic clk;
    logic reset;
    logic uart_tx;
    logic tx_busy;
    logic fifo_full;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_DATA   (ADDR_DATA),
        .ADDR_STATUS (ADDR_STATUS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy),
        .fifo_full(fifo_full)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_edge = 0;
    int         first_edge = 0;
    rx_t        rx_q[$];
    logic [7:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
        $fatal(1, "watchdog");
    end

    // Line value of bit slot idx in a frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx - 1];
        if (NBITS == 11 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    // Line monitor: finds start bits and samples each bit slot in its middle.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (uart_tx === 1'b0 && reset === 1'b0) begin
                logic [NBITS-1:0] bits;
                bit               aborted;
                rx_t              f;
                aborted = 1'b0;
                bits    = '0;
                for (int j = 0; j < NBITS; j++) begin
                    repeat ((j == 0) ? CPB / 2 : CPB) begin
                        @(posedge clk); #2;
                        if (reset !== 1'b0) aborted = 1'b1;
                    end
                    bits[j] = uart_tx;
                end
                f.data = bits[8:1];
                f.ok   = (bits[0] === 1'b0) && (bits[NBITS-1] === 1'b1);
`ifdef MMIO_UART_TX_PARITY_EN
                f.ok   = f.ok && (bits[9] === ^bits[8:1]);
`endif
                if (!aborted) rx_q.push_back(f);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        bus.we    = 1'b1;
        bus.addr  = addr;
        bus.wdata = {24'hA5A5A5, data};
        @(posedge clk); #1;
        bus.we    = 1'b0;
        last_edge = cyc;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [31:0] data);
        bus.re   = 1'b1;
        bus.addr = addr;
        @(posedge clk); #1;
        bus.re   = 1'b0;
        data     = bus.rdata;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        tick(2);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1;
        tick(2);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full: got %b expected 0", fifo_full); end
        reset = 1'b0;
        do_read(ADDR_STATUS, r);
        checks++; if (r !== (32'h1 | PAR_FLAG)) begin errors++; $display("FAIL reset_status: got %h expected %h", r, 32'h1 | PAR_FLAG); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_idle_line: got %b expected 1", uart_tx); end
    endtask

    task automatic test_single_frame();
        logic exp_bit;
        rx_q.delete();
        do_write(ADDR_DATA, 8'h55);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_pre_start: got %b expected 1", uart_tx); end
        tick(1);
        for (int i = 0; i < FRAME; i++) begin
            exp_bit = frame_bit(8'h55, i / CPB);
            checks++; if (uart_tx !== exp_bit) begin errors++; $display("FAIL frame_line[%0d]: got %b expected %b", i, uart_tx, exp_bit); end
            checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy[%0d]: got %b expected 1", i, tx_busy); end
            tick(1);
        end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_fall: got %b expected 0", tx_busy); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_idle_line: got %b expected 1", uart_tx); end
        tick(2);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL frame_rx_count: got %0d expected 1", rx_q.size());
        end else if (rx_q[0].data !== 8'h55 || !rx_q[0].ok) begin
            errors++; $display("FAIL frame_rx_byte: got %h ok=%0d expected 55 ok=1", rx_q[0].data, rx_q[0].ok);
        end
    endtask

    task automatic test_random_bytes();
        logic [31:0] r;
        logic [15:0] a;
        logic [7:0]  b;
        bit          ok;
        int          sel;
        rx_q.delete();
        exp_q.delete();
        do_read(ADDR_DATA, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL read_data_reg: got %h expected 00000000", r); end
        for (int round = 0; round < 5; round++) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7) begin
                    b = 8'($urandom);
                    do_write(ADDR_DATA, b);
                    exp_q.push_back(b);
                end else if (sel == 7) begin
                    a = 16'($urandom_range(0, 65535));
                    if (a == ADDR_DATA) a = a ^ 16'h0001;
                    do_write(a, 8'($urandom));
                end else begin
                    a = 16'($urandom_range(0, 65535));
                    if (a == ADDR_STATUS) a = a ^ 16'h0001;
                    do_read(a, r);
                    checks++; if (r !== 32'h0) begin errors++; $display("FAIL read_other_addr %h: got %h expected 00000000", a, r); end
                end
            end
            tick(int'($urandom_range(0, 60)));
        end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL random_drain_timeout: got busy expected idle"); end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i].data !== exp_q[i] || !rx_q[i].ok) begin
                    errors++; $display("FAIL random_rx[%0d]: got %h ok=%0d expected %h ok=1", i, rx_q[i].data, rx_q[i].ok, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        logic [7:0]  b;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom);
            do_write(ADDR_DATA, b);
            if (i == 0) first_edge = last_edge;
            if (i < 17) exp_q.push_back(b);
            if (i == 15) begin
                checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL full_at_15: got %b expected 0", fifo_full); end
            end
            if (i == 16) begin
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_at_16: got %b expected 1", fifo_full); end
            end
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_after_drop: got %b expected 1", fifo_full); end
        do_read(ADDR_STATUS, r);
        checks++; if (r !== (32'h0000_100E | PAR_FLAG)) begin errors++; $display("FAIL overflow_status: got %h expected %h", r, 32'h0000_100E | PAR_FLAG); end
        do_read(ADDR_STATUS, r);
        checks++; if (r !== (32'h0000_1006 | PAR_FLAG)) begin errors++; $display("FAIL overflow_cleared: got %h expected %h", r, 32'h0000_1006 | PAR_FLAG); end
        tick(1);
        checks++; if (bus.rdata !== (32'h0000_1006 | PAR_FLAG)) begin errors++; $display("FAIL rdata_hold: got %h expected %h", bus.rdata, 32'h0000_1006 | PAR_FLAG); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] r;
        logic [7:0]  b;
        bit          ok;
        int          pop_edge;
        // First pop one edge after the first push; each later pop follows a full frame plus one IDLE cycle.
        pop_edge = first_edge + 1 + FRAME + 1;
        while (cyc < pop_edge - 1) tick(1);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_before_pop: got %b expected 1", fifo_full); end
        b = 8'($urandom);
        do_write(ADDR_DATA, b);
        exp_q.push_back(b);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_after_push_pop: got %b expected 1", fifo_full); end
        do_read(ADDR_STATUS, r);
        checks++; if (r !== (32'h0000_1006 | PAR_FLAG)) begin errors++; $display("FAIL push_pop_status: got %h expected %h", r, 32'h0000_1006 | PAR_FLAG); end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_drain_timeout: got busy expected idle"); end
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL burst_rx_count: got %0d expected %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[i].data !== exp_q[i] || !rx_q[i].ok) begin
                    errors++; $display("FAIL burst_rx[%0d]: got %h ok=%0d expected %h ok=1", i, rx_q[i].data, rx_q[i].ok, exp_q[i]);
                end
            end
        end
        do_read(ADDR_STATUS, r);
        checks++; if (r !== (32'h1 | PAR_FLAG)) begin errors++; $display("FAIL burst_end_status: got %h expected %h", r, 32'h1 | PAR_FLAG); end
    endtask

`ifdef MMIO_UART_TX_PARITY_EN
    task automatic test_parity();
        int off;
        rx_q.delete();
        do_write(ADDR_DATA, 8'h07);
        tick(1);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL parity_start: got %b expected 0", uart_tx); end
        off = 9 * CPB + CPB / 2;
        tick(off);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL parity_bit: got %b expected 1", uart_tx); end
        tick(11 * CPB - 1 - off);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL parity_busy_end: got %b expected 1", tx_busy); end
        tick(1);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL parity_frame_len: got %b expected 0", tx_busy); end
        tick(2);
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        int          mid_edge;
        rx_q.delete();
        do_write(ADDR_DATA, 8'hA3);
        // Middle of slot 4 (data bit 3), counting from the pop one edge after the push.
        mid_edge = last_edge + 1 + 4 * CPB + CPB / 2;
        do_write(ADDR_DATA, 8'h3C);
        while (cyc < mid_edge) tick(1);
        checks++; if (uart_tx !== frame_bit(8'hA3, 4)) begin errors++; $display("FAIL abort_pre_bit3: got %b expected %b", uart_tx, frame_bit(8'hA3, 4)); end
        reset = 1'b1;
        tick(1);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL abort_line: got %b expected 1", uart_tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", tx_busy); end
        reset = 1'b0;
        do_read(ADDR_STATUS, r);
        checks++; if (r !== (32'h1 | PAR_FLAG)) begin errors++; $display("FAIL abort_status: got %h expected %h", r, 32'h1 | PAR_FLAG); end
        tick(3 * FRAME);
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL abort_discard: got %0d frames expected 0", rx_q.size()); end
        checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL abort_quiet: got line=%b busy=%b expected line=1 busy=0", uart_tx, tx_busy); end
    endtask

    initial begin
        reset     = 1'b1;
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.addr  = 16'h0;
        bus.wdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_single_frame();
        test_random_bytes();
        test_overflow();
        test_full_push_pop();
`ifdef MMIO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
